clk_div_tick_gen: RTL

Parametrised successor to the fixed 100 ms clock divider. It turns the system clock into a runtime-programmable base tick, plus N_DEC cascaded decade ticks and BCD digits (e.g. 0.1 s, 1 s, 10 s) for the stopwatch datapath. A clk_out pin is selectable between a one-cycle pulse and a 50% toggle. The block adds enable/pause, synchronous clear and divisor reload, which the fixed divider lacks.

---
 rtl/clk_div_tick_gen.sv | 79 +++++++
 1 files changed

// File: rtl/clk_div_tick_gen.sv
// Programmable base-tick divider with cascaded BCD decade counters and a
// clock output selectable between a one-cycle pulse and a 50% toggle.
module clk_div_tick_gen #(
    parameter int          CNT_W       = 32,
    parameter int unsigned DIV_DEFAULT = 5000000,
    parameter int          N_DEC       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               mode,
    input  logic               div_load,
    input  logic [CNT_W-1:0]   div_val,
    output logic               base_tick,
    output logic [N_DEC-1:0]   dec_tick,
    output logic [4*N_DEC-1:0] dec_val,
    output logic               clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]      div_reg;
    logic [CNT_W-1:0]      cnt;
    logic [N_DEC-1:0][3:0] dec_cnt;
    logic                  tgl;
    logic                  load_ok;
    logic                  run;
    logic [N_DEC-1:0]      stage_in;

    // A zero divisor would make div_reg-1 wrap, so such loads are dropped.
    assign load_ok   = div_load && (div_val != '0);
    assign run       = rst_n && en && !clr && !load_ok;
    assign base_tick = run && (cnt == div_reg - ONE);

    // Carries ripple combinationally so coinciding wraps tick in one cycle.
    always_comb begin
        logic carry;
        carry    = base_tick;
        stage_in = '0;
        dec_tick = '0;
        for (int i = 0; i < N_DEC; i++) begin
            stage_in[i] = carry;
            dec_tick[i] = carry && (dec_cnt[i] == 4'd9);
            carry       = carry && (dec_cnt[i] == 4'd9);
        end
    end

    assign dec_val = dec_cnt;
    assign clk_out = mode ? tgl : base_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= DIV_RST;
            cnt     <= '0;
            dec_cnt <= '0;
            tgl     <= 1'b0;
        end else begin
            if (load_ok) begin
                div_reg <= div_val;
                cnt     <= '0;
            end
            if (clr) begin
                cnt     <= '0;
                dec_cnt <= '0;
                tgl     <= 1'b0;
            end else if (run) begin
                cnt <= base_tick ? '0 : cnt + ONE;
                tgl <= tgl ^ base_tick;
                for (int i = 0; i < N_DEC; i++) begin
                    if (stage_in[i])
                        dec_cnt[i] <= (dec_cnt[i] == 4'd9) ? 4'd0 : dec_cnt[i] + 4'd1;
                end
            end
        end
    end

endmodule
